// File: rtl/core_pkg.sv
// Shared core types: the reservation-station entry record and ROB age arithmetic.
package core_pkg;

  localparam int PHYS_W = 6;
  localparam int ROB_W  = 6;
  localparam int DATA_W = 64;
  localparam int OP_W   = 8;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [ROB_W-1:0]  rob_tag;
    logic [PHYS_W-1:0] dst_tag;
    logic [PHYS_W-1:0] src1_tag;
    logic [PHYS_W-1:0] src2_tag;
    logic              src1_rdy;
    logic              src2_rdy;
    logic [DATA_W-1:0] src1_val;
    logic [DATA_W-1:0] src2_val;
  } rs_entry_t;

  // Distance of a ROB tag from the head; larger means younger, wrap handled by modulo.
  function automatic logic [ROB_W-1:0] rob_rel_age(input logic [ROB_W-1:0] tag,
                                                   input logic [ROB_W-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// One-hot grant of the oldest requester; age_i[a][b] = 1 means entry a is older than entry b.
module rs_oldest_select #(
  parameter int N = 16
) (
  input  logic [N-1:0]        req_i,
  input  logic [N-1:0][N-1:0] age_i,
  output logic [N-1:0]        grant_o
);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      grant_o[i] = req_i[i];
      for (int j = 0; j < N; j++) begin
        if (req_i[j] && age_i[j][i]) grant_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_age_matrix_queue.sv
// Unified reservation station ordered by an age matrix, with CDB wakeup/bypass,
// valid/ready issue ports and selective squash of entries younger than a branch.
module rs_age_matrix_queue
  import core_pkg::*;
#(
  parameter int RS_ENTRIES = 16,
  parameter int ALLOC_W    = 2,
  parameter int ISSUE_W    = 2,
  parameter int CDB_W      = 2,
  localparam int FC_W      = $clog2(RS_ENTRIES + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush_all,
  input  logic                            squash_valid,
  input  logic [ROB_W-1:0]                squash_rob_tag,
  input  logic [ROB_W-1:0]                rob_head,
  input  logic [ALLOC_W-1:0]              alloc_valid,
  output logic                            alloc_ready,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0]  alloc_dst_tag,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0]  alloc_src1_tag,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0]  alloc_src2_tag,
  input  logic [ALLOC_W-1:0][DATA_W-1:0]  alloc_src1_val,
  input  logic [ALLOC_W-1:0][DATA_W-1:0]  alloc_src2_val,
  input  logic [ALLOC_W-1:0]              alloc_src1_ready,
  input  logic [ALLOC_W-1:0]              alloc_src2_ready,
  input  logic [ALLOC_W-1:0][OP_W-1:0]    alloc_op,
  input  logic [ALLOC_W-1:0][ROB_W-1:0]   alloc_rob_tag,
  input  logic [CDB_W-1:0]                cdb_valid,
  input  logic [CDB_W-1:0][PHYS_W-1:0]    cdb_tag,
  input  logic [CDB_W-1:0][DATA_W-1:0]    cdb_value,
  // Issue handshake: a port transfers at the edge where issue_valid && issue_ready;
  // issue_valid never depends on issue_ready, and fields are zero while issue_valid is 0.
  output logic [ISSUE_W-1:0]              issue_valid,
  input  logic [ISSUE_W-1:0]              issue_ready,
  output logic [ISSUE_W-1:0][OP_W-1:0]    issue_op,
  output logic [ISSUE_W-1:0][PHYS_W-1:0]  issue_dst_tag,
  output logic [ISSUE_W-1:0][ROB_W-1:0]   issue_rob_tag,
  output logic [ISSUE_W-1:0][DATA_W-1:0]  issue_src1_val,
  output logic [ISSUE_W-1:0][DATA_W-1:0]  issue_src2_val,
  output logic [FC_W-1:0]                 free_count
);

  localparam int IDX_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

  rs_entry_t [RS_ENTRIES-1:0]                 entries_q, entries_d;
  logic      [RS_ENTRIES-1:0][RS_ENTRIES-1:0] age_q, age_d;
  logic      [FC_W-1:0]                       free_count_q, free_count_d;
  logic      [RS_ENTRIES-1:0]                 valid_vec, rdy_vec, kill, deq;
  logic      [ISSUE_W-1:0][RS_ENTRIES-1:0]    grant_all;
  logic                                       alloc_fire;

  assign alloc_ready = (free_count_q >= FC_W'(ALLOC_W));
  assign free_count  = free_count_q;
  assign alloc_fire  = alloc_ready && !squash_valid && !flush_all;

  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      rdy_vec[i]   = entries_q[i].valid && entries_q[i].src1_rdy && entries_q[i].src2_rdy;
      kill[i]      = entries_q[i].valid && squash_valid &&
                     (rob_rel_age(entries_q[i].rob_tag, rob_head) >
                      rob_rel_age(squash_rob_tag, rob_head));
    end
  end

  // Each port sees the ready set minus everything granted to lower-numbered ports.
  for (genvar p = 0; p < ISSUE_W; p++) begin : g_port
    logic [RS_ENTRIES-1:0] req, grant, used;
    if (p == 0) begin : g_first
      assign req  = rdy_vec;
      assign used = grant;
    end else begin : g_next
      assign req  = rdy_vec & ~g_port[p-1].used;
      assign used = g_port[p-1].used | grant;
    end
    rs_oldest_select #(.N(RS_ENTRIES)) u_sel (
      .req_i   (req),
      .age_i   (age_q),
      .grant_o (grant)
    );
    assign grant_all[p] = grant;
  end

  always_comb begin
    deq = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      issue_valid[p]    = (|grant_all[p]) && !(|(grant_all[p] & kill)) && !flush_all;
      issue_op[p]       = '0;
      issue_dst_tag[p]  = '0;
      issue_rob_tag[p]  = '0;
      issue_src1_val[p] = '0;
      issue_src2_val[p] = '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (grant_all[p][i] && issue_valid[p]) begin
          issue_op[p]       = entries_q[i].op;
          issue_dst_tag[p]  = entries_q[i].dst_tag;
          issue_rob_tag[p]  = entries_q[i].rob_tag;
          issue_src1_val[p] = entries_q[i].src1_val;
          issue_src2_val[p] = entries_q[i].src2_val;
          if (issue_ready[p]) deq[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rs_entry_t             ne;
    logic [RS_ENTRIES-1:0] alloc_mask;
    logic [IDX_W-1:0]      slot;
    logic                  found;
    int                    n_alloc;
    int                    n_rem;
    int                    fc;
    entries_d  = entries_q;
    age_d      = age_q;
    ne         = '0;
    alloc_mask = '0;
    slot       = '0;
    found      = 1'b0;
    n_alloc    = 0;
    n_rem      = 0;

    // Removal wins over wakeup; lowest CDB lane is applied last so it wins on duplicates.
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (kill[i] || deq[i]) begin
        entries_d[i].valid = 1'b0;
        n_rem++;
      end else if (entries_q[i].valid) begin
        for (int b = CDB_W - 1; b >= 0; b--) begin
          if (cdb_valid[b] && !entries_q[i].src1_rdy && cdb_tag[b] == entries_q[i].src1_tag) begin
            entries_d[i].src1_rdy = 1'b1;
            entries_d[i].src1_val = cdb_value[b];
          end
          if (cdb_valid[b] && !entries_q[i].src2_rdy && cdb_tag[b] == entries_q[i].src2_tag) begin
            entries_d[i].src2_rdy = 1'b1;
            entries_d[i].src2_val = cdb_value[b];
          end
        end
      end
    end

    if (alloc_fire) begin
      for (int l = 0; l < ALLOC_W; l++) begin
        if (alloc_valid[l]) begin
          found = 1'b0;
          slot  = '0;
          for (int s = 0; s < RS_ENTRIES; s++) begin
            if (!found && !valid_vec[s] && !alloc_mask[s]) begin
              found = 1'b1;
              slot  = IDX_W'(s);
            end
          end
          if (found) begin
            ne          = '0;
            ne.valid    = 1'b1;
            ne.op       = alloc_op[l];
            ne.rob_tag  = alloc_rob_tag[l];
            ne.dst_tag  = alloc_dst_tag[l];
            ne.src1_tag = alloc_src1_tag[l];
            ne.src2_tag = alloc_src2_tag[l];
            ne.src1_rdy = alloc_src1_ready[l];
            ne.src2_rdy = alloc_src2_ready[l];
            ne.src1_val = alloc_src1_val[l];
            ne.src2_val = alloc_src2_val[l];
            for (int b = CDB_W - 1; b >= 0; b--) begin
              if (cdb_valid[b] && !alloc_src1_ready[l] && cdb_tag[b] == alloc_src1_tag[l]) begin
                ne.src1_rdy = 1'b1;
                ne.src1_val = cdb_value[b];
              end
              if (cdb_valid[b] && !alloc_src2_ready[l] && cdb_tag[b] == alloc_src2_tag[l]) begin
                ne.src2_rdy = 1'b1;
                ne.src2_val = cdb_value[b];
              end
            end
            entries_d[slot] = ne;
            // Every resident entry and every earlier lane is older than the new one.
            for (int k = 0; k < RS_ENTRIES; k++) begin
              age_d[k][slot] = valid_vec[k] | alloc_mask[k];
            end
            age_d[slot]      = '0;
            alloc_mask[slot] = 1'b1;
            n_alloc++;
          end
        end
      end
    end

    fc           = int'(free_count_q) + n_rem - n_alloc;
    free_count_d = FC_W'(fc);

    if (flush_all) begin
      for (int i = 0; i < RS_ENTRIES; i++) entries_d[i].valid = 1'b0;
      age_d        = '0;
      free_count_d = FC_W'(RS_ENTRIES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries_q    <= '0;
      age_q        <= '0;
      free_count_q <= FC_W'(RS_ENTRIES);
    end else begin
      entries_q    <= entries_d;
      age_q        <= age_d;
      free_count_q <= free_count_d;
    end
  end

endmodule

// File: tb/tb_rs_age_matrix_queue.sv
// Directed bench for rs_age_matrix_queue: issue order, wakeup/bypass, stall, full, squash, flush.
module tb_rs_age_matrix_queue;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush_all, squash_valid;
  logic [5:0]       squash_rob_tag, rob_head;
  logic [1:0]       alloc_valid;
  logic             alloc_ready;
  logic [1:0][5:0]  alloc_dst_tag, alloc_src1_tag, alloc_src2_tag;
  logic [1:0][63:0] alloc_src1_val, alloc_src2_val;
  logic [1:0]       alloc_src1_ready, alloc_src2_ready;
  logic [1:0][7:0]  alloc_op;
  logic [1:0][5:0]  alloc_rob_tag;
  logic [1:0]       cdb_valid;
  logic [1:0][5:0]  cdb_tag;
  logic [1:0][63:0] cdb_value;
  logic [1:0]       issue_valid, issue_ready;
  logic [1:0][7:0]  issue_op;
  logic [1:0][5:0]  issue_dst_tag, issue_rob_tag;
  logic [1:0][63:0] issue_src1_val, issue_src2_val;
  logic [4:0]       free_count;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  rs_age_matrix_queue #(
    .RS_ENTRIES(16), .ALLOC_W(2), .ISSUE_W(2), .CDB_W(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush_all        (flush_all),
    .squash_valid     (squash_valid),
    .squash_rob_tag   (squash_rob_tag),
    .rob_head         (rob_head),
    .alloc_valid      (alloc_valid),
    .alloc_ready      (alloc_ready),
    .alloc_dst_tag    (alloc_dst_tag),
    .alloc_src1_tag   (alloc_src1_tag),
    .alloc_src2_tag   (alloc_src2_tag),
    .alloc_src1_val   (alloc_src1_val),
    .alloc_src2_val   (alloc_src2_val),
    .alloc_src1_ready (alloc_src1_ready),
    .alloc_src2_ready (alloc_src2_ready),
    .alloc_op         (alloc_op),
    .alloc_rob_tag    (alloc_rob_tag),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .cdb_value        (cdb_value),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_op         (issue_op),
    .issue_dst_tag    (issue_dst_tag),
    .issue_rob_tag    (issue_rob_tag),
    .issue_src1_val   (issue_src1_val),
    .issue_src2_val   (issue_src2_val),
    .free_count       (free_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    flush_all        = 1'b0;
    squash_valid     = 1'b0;
    squash_rob_tag   = '0;
    alloc_valid      = '0;
    alloc_dst_tag    = '0;
    alloc_src1_tag   = '0;
    alloc_src2_tag   = '0;
    alloc_src1_val   = '0;
    alloc_src2_val   = '0;
    alloc_src1_ready = '0;
    alloc_src2_ready = '0;
    alloc_op         = '0;
    alloc_rob_tag    = '0;
    cdb_valid        = '0;
    cdb_tag          = '0;
    cdb_value        = '0;
    issue_ready      = '0;
  endtask

  task automatic set_lane(input logic l, input logic [5:0] rob, input logic [5:0] s1tag,
                          input logic s1rdy, input logic [63:0] s1val);
    alloc_valid[l]      = 1'b1;
    alloc_rob_tag[l]    = rob;
    alloc_dst_tag[l]    = rob;
    alloc_op[l]         = {2'b01, rob};
    alloc_src1_tag[l]   = s1tag;
    alloc_src1_ready[l] = s1rdy;
    alloc_src1_val[l]   = s1val;
    alloc_src2_tag[l]   = 6'd0;
    alloc_src2_ready[l] = 1'b1;
    alloc_src2_val[l]   = 64'h5;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input logic p);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL issue_order observed=%0h expected=empty_queue", issue_rob_tag[p]);
    end else begin
      e = exp_q.pop_front();
      chk("issue_order", issue_rob_tag[p], e);
    end
  endtask

  initial begin
    idle();
    rob_head = '0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_free_count", free_count, 16);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_issue_valid", issue_valid, 0);

    // two ready ops issue together the next cycle, oldest on port 0
    set_lane(1'b0, 6'd3, 6'd0, 1'b1, 64'h10);
    set_lane(1'b1, 6'd4, 6'd0, 1'b1, 64'h11);
    tick(); idle(); #1;
    chk("t1_issue_valid", issue_valid, 2'b11);
    exp_q.push_back(6'd3);
    exp_q.push_back(6'd4);
    chk_issue(1'b0);
    chk_issue(1'b1);
    chk("t1_src1_val", issue_src1_val[0], 64'h10);
    chk("t1_op", issue_op[1], {2'b01, 6'd4});
    chk("t1_free_count", free_count, 14);
    issue_ready = 2'b11;
    tick(); idle(); #1;
    chk("t1_drained_valid", issue_valid, 0);
    chk("t1_drained_free", free_count, 16);

    // wakeup a cycle after allocation
    set_lane(1'b0, 6'd5, 6'd9, 1'b0, 64'h0);
    tick(); idle(); #1;
    chk("t2a_wait_valid", issue_valid, 0);
    chk("t2a_free", free_count, 15);
    cdb_valid = 2'b01; cdb_tag[0] = 6'd9; cdb_value[0] = 64'hAB;
    #1;
    chk("t2a_cdb_cycle_valid", issue_valid, 0);
    tick(); idle(); #1;
    chk("t2a_wake_valid", issue_valid, 2'b01);
    chk("t2a_wake_val", issue_src1_val[0], 64'hAB);
    chk("t2a_wake_rob", issue_rob_tag[0], 5);
    issue_ready = 2'b01;
    tick(); idle(); #1;
    chk("t2a_free_after", free_count, 16);

    // same-cycle bypass on allocation, lowest CDB lane wins a duplicate tag
    set_lane(1'b0, 6'd6, 6'd9, 1'b0, 64'h0);
    cdb_valid = 2'b11;
    cdb_tag[0] = 6'd9; cdb_value[0] = 64'hCD;
    cdb_tag[1] = 6'd9; cdb_value[1] = 64'hEE;
    #1;
    chk("t2b_alloc_cycle_valid", issue_valid, 0);
    tick(); idle(); #1;
    chk("t2b_bypass_valid", issue_valid, 2'b01);
    chk("t2b_bypass_val", issue_src1_val[0], 64'hCD);
    issue_ready = 2'b01;
    tick(); idle();

    // stalled port holds its entry
    set_lane(1'b0, 6'd7, 6'd0, 1'b1, 64'h77);
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3_stall_valid", issue_valid, 2'b01);
      chk("t3_stall_rob", issue_rob_tag[0], 7);
      chk("t3_stall_free", free_count, 15);
      tick();
    end
    issue_ready = 2'b01;
    #1;
    chk("t3_release_valid", issue_valid, 2'b01);
    tick(); idle(); #1;
    chk("t3_release_free", free_count, 16);
    chk("t3_release_empty", issue_valid, 0);

    // fill all sixteen slots with waiting entries
    for (int k = 0; k < 8; k++) begin
      set_lane(1'b0, 6'(10 + 2 * k), 6'd20, 1'b0, 64'h0);
      set_lane(1'b1, 6'(11 + 2 * k), 6'd20, 1'b0, 64'h0);
      tick(); idle();
    end
    #1;
    chk("t4_full_alloc_ready", alloc_ready, 0);
    chk("t4_full_free", free_count, 0);
    set_lane(1'b0, 6'd40, 6'd0, 1'b1, 64'h1);
    set_lane(1'b1, 6'd41, 6'd0, 1'b1, 64'h2);
    tick(); idle(); #1;
    chk("t4_dropped_free", free_count, 0);
    chk("t4_no_overwrite", issue_valid, 0);
    cdb_valid = 2'b01; cdb_tag[0] = 6'd20; cdb_value[0] = 64'h99;
    tick(); idle(); #1;
    chk("t4_wake_valid", issue_valid, 2'b11);
    exp_q.push_back(6'd10);
    exp_q.push_back(6'd11);
    chk_issue(1'b0);
    chk_issue(1'b1);
    chk("t4_wake_val", issue_src1_val[1], 64'h99);
    issue_ready = 2'b11;
    tick(); idle(); #1;
    chk("t4_after_deq_free", free_count, 2);
    chk("t4_after_deq_ready", alloc_ready, 1);
    exp_q.push_back(6'd12);
    exp_q.push_back(6'd13);
    chk_issue(1'b0);
    chk_issue(1'b1);

    // flush overrides issue, wakeup and allocation
    flush_all   = 1'b1;
    issue_ready = 2'b11;
    cdb_valid   = 2'b11; cdb_tag[0] = 6'd20; cdb_tag[1] = 6'd21;
    set_lane(1'b0, 6'd50, 6'd0, 1'b1, 64'h3);
    set_lane(1'b1, 6'd51, 6'd0, 1'b1, 64'h4);
    tick(); idle(); #1;
    chk("t6_flush_free", free_count, 16);
    chk("t6_flush_valid", issue_valid, 0);
    chk("t6_flush_alloc_ready", alloc_ready, 1);
    tick(); #1;
    chk("t6_flush_stays_empty", issue_valid, 0);

    // wrap-aware squash with head at 60
    rob_head = 6'd60;
    set_lane(1'b0, 6'd62, 6'd30, 1'b0, 64'h0);
    set_lane(1'b1, 6'd1, 6'd30, 1'b0, 64'h0);
    tick(); idle();
    set_lane(1'b0, 6'd5, 6'd30, 1'b0, 64'h0);
    tick(); idle(); #1;
    chk("t5_pre_free", free_count, 13);
    squash_valid   = 1'b1;
    squash_rob_tag = 6'd1;
    set_lane(1'b0, 6'd7, 6'd0, 1'b1, 64'h8);
    tick(); idle(); #1;
    chk("t5_squash_free", free_count, 14);
    chk("t5_squash_no_issue", issue_valid, 0);
    cdb_valid = 2'b01; cdb_tag[0] = 6'd30; cdb_value[0] = 64'h30;
    tick(); idle(); #1;
    chk("t5_survivors_valid", issue_valid, 2'b11);
    exp_q.push_back(6'd62);
    exp_q.push_back(6'd1);
    chk_issue(1'b0);
    chk_issue(1'b1);
    // squash behind rob 62 masks port 1 in the same cycle
    squash_valid   = 1'b1;
    squash_rob_tag = 6'd62;
    issue_ready    = 2'b11;
    #1;
    chk("t5_mask_valid", issue_valid, 2'b01);
    chk("t5_mask_rob0", issue_rob_tag[0], 62);
    chk("t5_mask_rob1_zero", issue_rob_tag[1], 0);
    tick(); idle(); #1;
    chk("t5_final_free", free_count, 16);
    chk("t5_final_valid", issue_valid, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
